// File: rtl/cpld_data_rx_pkg.sv
// rtl/cpld_data_rx_pkg.sv - shared types and constants for the CPLD data-mode receiver
package cpld_data_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RX   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam int DEF_LEN_W     = 20;
    localparam int DEF_TIMEOUT_W = 24;

    // CFG_Din carries the most significant bit of each byte first
    localparam bit MSB_FIRST = 1'b1;

    function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic bit_in);
        if (MSB_FIRST)
            return {cur[6:0], bit_in};
        else
            return {bit_in, cur[7:1]};
    endfunction

endpackage

// File: rtl/cpld_edge_sync.sv
// rtl/cpld_edge_sync.sv - CPLD_CLK/CFG_Din synchroniser with CPLD_CLK rising-edge detect
module cpld_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic cpld_clk_i,
    input  logic cpld_din_i,
    output logic clk_rise,
    output logic din_sync
);

    logic [1:0] clk_ff;
    logic [1:0] din_ff;
    logic       clk_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_ff <= 2'b00;
            din_ff <= 2'b00;
            clk_d  <= 1'b0;
        end else begin
            clk_ff <= {clk_ff[0], cpld_clk_i};
            din_ff <= {din_ff[0], cpld_din_i};
            clk_d  <= clk_ff[1];
        end
    end

    // din passes through the same depth as clk, so the bit seen here matches the edge
    assign clk_rise = clk_ff[1] & ~clk_d;
    assign din_sync = din_ff[1];

endmodule

// File: rtl/cpld_data_rx.sv
// rtl/cpld_data_rx.sv - boot CPLD data-mode receiver; optional checksum via CPLD_DATA_RX_CKSUM_EN
module cpld_data_rx
    import cpld_data_rx_pkg::*;
#(
    parameter int LEN_W     = DEF_LEN_W,
    parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             cpld_clk_i,
    input  logic             cpld_din_i,
    input  logic             cpld_detached_i,
    output logic             cpld_start_o,
    output logic             cpld_mode_o,
    output logic             cpld_done_o,
    output logic [7:0]       dout_o,
    output logic             dout_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [15:0]      cksum_o
);

    state_t               state;
    logic                 clk_rise;
    logic                 din_s;
    logic [1:0]           det_ff;
    logic [7:0]           shreg;
    logic [7:0]           shreg_nxt;
    logic [2:0]           bit_cnt;
    logic [LEN_W-1:0]     rem;
    logic [TIMEOUT_W-1:0] wd;
    logic                 wd_expire;
    logic                 byte_done;

    cpld_edge_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .cpld_clk_i (cpld_clk_i),
        .cpld_din_i (cpld_din_i),
        .clk_rise   (clk_rise),
        .din_sync   (din_s)
    );

    always_ff @(posedge clk) begin
        if (rst)
            det_ff <= 2'b00;
        else
            det_ff <= {det_ff[0], cpld_detached_i};
    end

    assign shreg_nxt = shift_in(shreg, din_s);
    // an edge arriving on the expiry cycle wins over the watchdog
    assign wd_expire = (wd == {TIMEOUT_W{1'b1}}) && !clk_rise;
    assign byte_done = (state == ST_RX) && clk_rise && (bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            shreg        <= 8'd0;
            bit_cnt      <= 3'd0;
            rem          <= '0;
            wd           <= '0;
            cpld_start_o <= 1'b0;
            cpld_mode_o  <= 1'b0;
            cpld_done_o  <= 1'b0;
            dout_o       <= 8'd0;
            dout_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            dout_valid_o <= 1'b0;
            done_o       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go_i) begin
                        timeout_o <= 1'b0;
                        if (len_i == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            rem          <= len_i;
                            busy_o       <= 1'b1;
                            cpld_start_o <= 1'b1;
                            cpld_mode_o  <= 1'b1;
                            bit_cnt      <= 3'd0;
                            wd           <= '0;
                            state        <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (clk_rise) begin
                        shreg   <= shreg_nxt;
                        bit_cnt <= 3'd1;
                        wd      <= '0;
                        state   <= ST_RX;
                    end else if (wd_expire) begin
                        timeout_o    <= 1'b1;
                        cpld_start_o <= 1'b0;
                        cpld_done_o  <= 1'b1;
                        wd           <= '0;
                        state        <= ST_FIN;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ST_RX: begin
                    if (clk_rise) begin
                        shreg   <= shreg_nxt;
                        bit_cnt <= bit_cnt + 3'd1;
                        wd      <= '0;
                        if (byte_done) begin
                            dout_o       <= shreg_nxt;
                            dout_valid_o <= 1'b1;
                            if (rem != '0)
                                rem <= rem - 1'b1;
                            if (rem <= LEN_W'(1)) begin
                                cpld_start_o <= 1'b0;
                                cpld_done_o  <= 1'b1;
                                state        <= ST_FIN;
                            end
                        end
                    end else if (wd_expire) begin
                        // partial byte in shreg is simply abandoned
                        timeout_o    <= 1'b1;
                        cpld_start_o <= 1'b0;
                        cpld_done_o  <= 1'b1;
                        wd           <= '0;
                        state        <= ST_FIN;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                ST_FIN: begin
                    if (det_ff[1] || wd_expire) begin
                        if (wd_expire && !det_ff[1])
                            timeout_o <= 1'b1;
                        cpld_start_o <= 1'b0;
                        cpld_done_o  <= 1'b0;
                        cpld_mode_o  <= 1'b0;
                        busy_o       <= 1'b0;
                        done_o       <= 1'b1;
                        wd           <= '0;
                        state        <= ST_IDLE;
                    end else if (clk_rise) begin
                        wd <= '0;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CPLD_DATA_RX_CKSUM_EN
    logic [15:0] cksum;

    always_ff @(posedge clk) begin
        if (rst)
            cksum <= 16'd0;
        else if (state == ST_IDLE && go_i)
            cksum <= 16'd0;
        else if (byte_done)
            cksum <= cksum + {8'd0, shreg_nxt};
    end

    assign cksum_o = cksum;
`else
    assign cksum_o = 16'd0;
`endif

endmodule

// File: tb/tb_cpld_data_rx.sv
// tb/tb_cpld_data_rx.sv - self-checking bench for cpld_data_rx
module tb_cpld_data_rx;

    localparam int LEN_W     = 20;
    localparam int TIMEOUT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             go_i;
    logic [LEN_W-1:0] len_i;
    logic             cpld_clk_i;
    logic             cpld_din_i;
    logic             cpld_detached_i;
    logic             cpld_start_o;
    logic             cpld_mode_o;
    logic             cpld_done_o;
    logic [7:0]       dout_o;
    logic             dout_valid_o;
    logic             busy_o;
    logic             done_o;
    logic             timeout_o;
    logic [15:0]      cksum_o;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          done_cnt   = 0;
    int          start_seen = 0;
    logic [15:0] last_cksum = 16'd0;

    cpld_data_rx #(.LEN_W(LEN_W), .TIMEOUT_W(TIMEOUT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .go_i            (go_i),
        .len_i           (len_i),
        .cpld_clk_i      (cpld_clk_i),
        .cpld_din_i      (cpld_din_i),
        .cpld_detached_i (cpld_detached_i),
        .cpld_start_o    (cpld_start_o),
        .cpld_mode_o     (cpld_mode_o),
        .cpld_done_o     (cpld_done_o),
        .dout_o          (dout_o),
        .dout_valid_o    (dout_valid_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .timeout_o       (timeout_o),
        .cksum_o         (cksum_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dout_valid_o) got_q.push_back(dout_o);
        if (done_o) begin
            done_cnt   = done_cnt + 1;
            last_cksum = cksum_o;
        end
        if (cpld_start_o) start_seen = start_seen + 1;
    end

    task automatic pulse_go(input logic [LEN_W-1:0] len);
        @(negedge clk);
        go_i  = 1'b1;
        len_i = len;
        @(negedge clk);
        go_i  = 1'b0;
    endtask

    // CPLD_CLK = clk/8; sends the top n bits of b, MSB first
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk);
            cpld_din_i = b[i];
            cpld_clk_i = 1'b0;
            repeat (3) @(negedge clk);
            cpld_clk_i = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; go_i = 1'b0; len_i = '0;
        cpld_clk_i = 1'b0; cpld_din_i = 1'b0; cpld_detached_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cpld_start_o, cpld_mode_o, cpld_done_o, dout_valid_o, busy_o, done_o, timeout_o} !== 7'd0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0000000",
                     {cpld_start_o, cpld_mode_o, cpld_done_o, dout_valid_o, busy_o, done_o, timeout_o});
        end
        checks++;
        if (dout_o !== 8'd0 || cksum_o !== 16'd0) begin
            failures++;
            $display("FAIL reset_data dout=%h cksum=%h want 0", dout_o, cksum_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stream;
        bit seen;
        exp_q.delete(); got_q.delete();
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        pulse_go(20'd4);
        checks++;
        if (cpld_start_o !== 1'b1 || cpld_mode_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL stream_req start=%b mode=%b busy=%b want 111", cpld_start_o, cpld_mode_o, busy_o);
        end
        send_bits(8'hA5, 8); send_bits(8'h3C, 8); send_bits(8'hFF, 8); send_bits(8'h00, 7);
        checks++;
        if (cpld_done_o !== 1'b0) begin
            failures++;
            $display("FAIL stream_done_early got=%b want=0", cpld_done_o);
        end
        send_bits(8'h00, 1);
        checks++;
        if (cpld_done_o !== 1'b1 || cpld_start_o !== 1'b0 || cpld_mode_o !== 1'b1) begin
            failures++;
            $display("FAIL stream_fin done=%b start=%b mode=%b want 101", cpld_done_o, cpld_start_o, cpld_mode_o);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL stream_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL stream_byte got=%h want=%h", g, e);
            end
        end
        cpld_detached_i = 1'b1;
        wait_done(20, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL stream_done_o got=none want=pulse");
        end
        @(negedge clk);
        checks++;
        if (timeout_o !== 1'b0 || busy_o !== 1'b0 || cpld_mode_o !== 1'b0 || cpld_done_o !== 1'b0) begin
            failures++;
            $display("FAIL stream_end timeout=%b busy=%b mode=%b cdone=%b want 0000",
                     timeout_o, busy_o, cpld_mode_o, cpld_done_o);
        end
        cpld_detached_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_zero_len;
        int s0;
        s0 = start_seen;
        pulse_go(20'd0);
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_done done=%b busy=%b want 10", done_o, busy_o);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (start_seen != s0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_start start_cycles=%0d want=0 done=%b", start_seen - s0, done_o);
        end
    endtask

    task automatic test_timeout;
        bit seen;
        exp_q.delete(); got_q.delete();
        exp_q.push_back(8'h5A);
        pulse_go(20'd2);
        send_bits(8'h5A, 8);
        send_bits(8'hF0, 4);
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (timeout_o) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL timeout_flag got=0 want=1");
        end
        checks++;
        if (cpld_done_o !== 1'b1 || cpld_start_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_fin cdone=%b start=%b want 10", cpld_done_o, cpld_start_o);
        end
        cpld_detached_i = 1'b1;
        wait_done(20, seen);
        checks++;
        if (!seen || timeout_o !== 1'b1) begin
            failures++;
            $display("FAIL timeout_done seen=%b timeout=%b want 11", seen, timeout_o);
        end
        checks++;
        if (got_q.size() != 1) begin
            failures++;
            $display("FAIL timeout_count got=%0d want=1", got_q.size());
        end else begin
            logic [7:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL timeout_byte got=%h want=%h", g, e);
            end
        end
        cpld_detached_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit seen;
        exp_q.delete(); got_q.delete();
        pulse_go(20'd3);
        send_bits(8'h5A, 8);
        send_bits(8'hF0, 4);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cpld_start_o, cpld_mode_o, cpld_done_o, dout_valid_o, busy_o, done_o, timeout_o} !== 7'd0) begin
            failures++;
            $display("FAIL reset_mid got=%b want=0000000",
                     {cpld_start_o, cpld_mode_o, cpld_done_o, dout_valid_o, busy_o, done_o, timeout_o});
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        got_q.delete();
        exp_q.push_back(8'hC3);
        pulse_go(20'd1);
        send_bits(8'hC3, 8);
        cpld_detached_i = 1'b1;
        wait_done(20, seen);
        checks++;
        if (!seen || got_q.size() != 1) begin
            failures++;
            $display("FAIL reset_mid_retry done=%b bytes=%0d want done=1 bytes=1", seen, got_q.size());
        end else begin
            logic [7:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL reset_mid_byte got=%h want=%h", g, e);
            end
        end
        cpld_detached_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_busy_ignore;
        bit seen;
        exp_q.delete(); got_q.delete();
        exp_q.push_back(8'h81);
        pulse_go(20'd1);
        pulse_go(20'd5);
        send_bits(8'h81, 8);
        checks++;
        if (cpld_done_o !== 1'b1) begin
            failures++;
            $display("FAIL busy_len cdone=%b want=1", cpld_done_o);
        end
        send_bits(8'h7E, 8);
        checks++;
        if (got_q.size() != 1) begin
            failures++;
            $display("FAIL busy_count got=%0d want=1", got_q.size());
        end else begin
            logic [7:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL busy_byte got=%h want=%h", g, e);
            end
        end
        cpld_detached_i = 1'b1;
        wait_done(20, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL busy_done got=none want=pulse");
        end
        cpld_detached_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_cksum;
        bit seen;
        logic [15:0] exp_sum;
        exp_q.delete(); got_q.delete();
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'hFF);
`ifdef CPLD_DATA_RX_CKSUM_EN
        exp_sum = 16'h0102;
`else
        exp_sum = 16'h0000;
`endif
        pulse_go(20'd3);
        send_bits(8'h01, 8); send_bits(8'h02, 8); send_bits(8'hFF, 8);
        cpld_detached_i = 1'b1;
        wait_done(20, seen);
        checks++;
        if (!seen || last_cksum !== exp_sum) begin
            failures++;
            $display("FAIL cksum done=%b got=%h want=%h", seen, last_cksum, exp_sum);
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL cksum_byte got=%h want=%h", g, e);
            end
        end
        checks++;
        if (exp_q.size() != 0 || got_q.size() != 0) begin
            failures++;
            $display("FAIL cksum_count left_exp=%0d left_got=%0d want 0", exp_q.size(), got_q.size());
        end
        cpld_detached_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_zero_len();
        test_timeout();
        test_reset_mid();
        test_busy_ignore();
        test_cksum();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

endmodule

// File: doc/cpld_data_rx.md
Name: cpld_data_rx

Overview:
- FPGA-side consumer of the boot CPLD's data-mode stream, running after configuration completes.
- Requests a data-mode transfer from the CPLD with START high and MODE=1.
- Deserialises the bits the CPLD clocks out on CPLD_CLK/CFG_Din (MSB first, sampled on the CPLD_CLK rising edge) into bytes, and delivers them as a valid-strobed byte stream.
- Ends the transfer with DONE and waits for the CPLD to detach before reporting completion.

Parameters:
- LEN_W, 20: width of the byte-count request (up to 1 MB per transfer).
- TIMEOUT_W, 24: width of the idle-edge watchdog; it expires after 2^TIMEOUT_W clk cycles without progress.

Ports:
- clk  in  1  system clock; one clock domain. clk must be at least 4x the CPLD_CLK frequency.
- rst  in  1  synchronous, active-high reset.
- go_i  in  1  single-cycle pulse; starts a transfer. Ignored while busy_o=1.
- len_i  in  LEN_W  number of bytes to receive; latched on go_i.
- cpld_clk_i  in  1  CPLD_CLK; asynchronous to clk.
- cpld_din_i  in  1  CFG_Din serial data; asynchronous to clk.
- cpld_detached_i  in  1  CPLD detached_o; high means the CPLD has released the interface.
- cpld_start_o  out  1  drives START.
- cpld_mode_o  out  1  drives MODE.
- cpld_done_o  out  1  drives DONE.
- dout_o  out  8  received byte.
- dout_valid_o  out  1  single-cycle strobe; dout_o is valid in that cycle.
- busy_o  out  1  high from go_i accepted until done_o.
- done_o  out  1  single-cycle completion pulse.
- timeout_o  out  1  sticky error flag; cleared on the next accepted go_i or on rst.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, all counters and synchronisers cleared. rst asserted mid-transfer drops cpld_start_o, cpld_mode_o and cpld_done_o to 0 in the next cycle. No handshake completion is attempted after reset.
- Input sync: cpld_clk_i, cpld_din_i and cpld_detached_i each pass through a 2-FF synchroniser.
  - Rising edge = sync_clk high and sync_clk_d low.
  - On a rising edge, the synchronised din is shifted into an 8-bit shift register, MSB first.
  - Edge-to-capture latency is 3 clk cycles.
- IDLE: cpld_start_o=0, cpld_mode_o=0, cpld_done_o=0.
  - go_i with len_i=0: done_o pulses on the next cycle and there is no CPLD activity.
  - go_i with len_i>0: latch len_i, clear timeout_o, set busy_o, go to REQ.
- REQ: cpld_start_o=1, cpld_mode_o=1.
  - First CPLD_CLK rising edge: go to RX; that edge's bit is captured.
- RX: cpld_start_o and cpld_mode_o stay at 1.
  - Every 8th captured bit: dout_o is loaded and dout_valid_o pulses in the following cycle; the remaining count decrements.
  - Count reaches 0: go to FIN. Bits arriving after the last byte are discarded.
- FIN: cpld_done_o=1, cpld_start_o=0, cpld_mode_o held at 1. Wait for synchronised cpld_detached_i=1.
  - Then: cpld_done_o=0, cpld_mode_o=0, done_o pulses, busy_o=0, return to IDLE.
- Watchdog: counts clk cycles in REQ, RX and FIN, and reloads on every CPLD_CLK rising edge and every state change.
  - On expiry: set timeout_o, go to FIN. A partial byte is discarded, never emitted.
  - If the watchdog also expires in FIN: drop all CPLD outputs, pulse done_o, return to IDLE.
- Simultaneous events: go_i while busy is ignored. An edge in the same cycle as watchdog expiry counts as the edge; the watchdog does not fire.
- Counter arithmetic is unsigned LEN_W-bit, with no wrap: the decrement is suppressed at 0.

Optional Feature:
- Macro CPLD_DATA_RX_CKSUM_EN.
- Defined: adds output cksum_o[15:0], the 16-bit modulo-2^16 sum of all bytes emitted in the current transfer. It clears on go_i and is valid when done_o pulses.
- Undefined: cksum_o is still present and tied to 16'd0, and no adder is built.

Decomposition:
- Shared package cpld_data_rx_pkg holds:
  - FSM state encoding: IDLE, REQ, RX, FIN (2 bits).
  - Default LEN_W and TIMEOUT_W constants.
  - Bit-order constant (MSB first).
- One sub-module, cpld_edge_sync: a 2-FF synchroniser plus rising-edge detector for cpld_clk_i, with a data synchroniser for cpld_din_i.

Test Plan:
- len_i=4, CPLD_CLK = clk/8 with bytes A5,3C,FF,00 MSB first → four dout_valid_o pulses with those values; cpld_done_o rises after the 32nd bit; detached=1 → done_o one cycle later; timeout_o=0.
- go_i with len_i=0 → done_o on the next cycle; cpld_start_o never asserted.
- Stall CPLD_CLK after 12 bits with len_i=2, TIMEOUT_W=8 → one byte emitted; timeout_o=1 after 256 idle cycles; cpld_done_o asserted; no second byte.
- rst pulsed mid-RX → all outputs 0 in the next cycle; a following go_i with len_i=1 completes normally.
- go_i repeated while busy → ignored; len stays at the originally latched value.
- CPLD_DATA_RX_CKSUM_EN defined, bytes 01,02,FF → cksum_o=0x0102 when done_o pulses.
